color_scan_sched: RTL and testbench
===================================

Name: color_scan_sched

Overview:
- Scheduler that time-shares the single colour-filter/centroid datapath across up to three colours: red, green and blue.
- Per colour it programs the filter select, admits one captured frame into processing, and collects the resulting centroid and proximity.
- After the last enabled colour it publishes the best target.
- Sits between the camera capture logic and the design top: drives its filter select and new-frame inputs, and consumes its centroid, proximity and new-centroid outputs.

Parameters:
- c_nb_centroid, 8: centroid width. Decoded one-hot-ish bit pattern; 0 means not detected.
- c_nb_prox, 3: proximity width. 0 is far, 7 is close.
- c_nb_timeout, 20: width of the result-wait counter.
- c_timeout_cycles, 500000: cycles allowed between a forwarded frame and new_centroid_i.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- en_i  in  1  scanning enable (level)
- color_en_i  in  3  colours to scan: bit2 red, bit1 green, bit0 blue
- capture_newframe_i  in  1  1-clk pulse from camera capture: a frame is complete in the input buffer
- new_centroid_i  in  1  1-clk pulse from the centroid stage: result valid
- centroid_i  in  c_nb_centroid  centroid for the current filter
- proximity_i  in  c_nb_prox  proximity for the current filter
- rgbfilter_o  out  3  filter select to the datapath: 100 red, 010 green, 001 blue, 000 none
- newframe_o  out  1  gated frame pulse to the datapath
- busy_o  out  1  scan in progress
- scan_done_o  out  1  1-clk pulse when a full scan completes
- found_o  out  1  at least one colour was detected in the last scan
- best_color_o  out  3  filter code of the best colour (000 if none)
- best_centroid_o  out  c_nb_centroid  centroid of the best colour
- best_prox_o  out  c_nb_prox  proximity of the best colour
- timeout_o  out  1  1-clk pulse when a result wait expires

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0 and all internal registers 0.
- States: IDLE, SELECT, WAIT_FRAME, WAIT_RESULT, DONE. All outputs are registered.
- IDLE:
  - rgbfilter_o=000, busy_o=0.
  - If en_i=1 and color_en_i!=0: latch color_en_i into scan_mask, clear the working best (prox 0, centroid 0, colour 000, found 0), go to SELECT.
  - color_en_i changes during a scan are ignored until the next start.
- SELECT:
  - Pick the next enabled colour in fixed order red, green, blue from scan_mask.
  - Drive rgbfilter_o with its code; it is held constant until that colour leaves WAIT_RESULT.
  - Go to WAIT_FRAME next cycle. busy_o=1 in every state except IDLE.
- WAIT_FRAME:
  - On capture_newframe_i=1: newframe_o=1 for exactly the following cycle, clear the timeout counter, go to WAIT_RESULT.
  - rgbfilter_o is therefore stable at least 1 cycle before the frame is admitted.
  - capture_newframe_i pulses in any other state are dropped; newframe_o is never asserted outside this path.
- WAIT_RESULT:
  - Counter increments each cycle.
  - On new_centroid_i=1, the result is a candidate if centroid_i!=0. The candidate replaces the working best if found=0 or proximity_i > working prox (strictly greater). Ties keep the earlier colour.
  - If the counter reaches c_timeout_cycles-1 without new_centroid_i: timeout_o=1 for 1 cycle; the colour is treated as not detected.
  - Either way: if more enabled colours remain, go to SELECT, else go to DONE.
  - If new_centroid_i and the timeout hit occur in the same cycle, new_centroid_i wins and there is no timeout pulse.
  - capture_newframe_i in this state is ignored.
- DONE:
  - Copy the working best into best_*_o and found_o; scan_done_o=1 for 1 cycle.
  - If en_i=1, rescan: re-latch color_en_i and go to SELECT. If the new mask is 0, go to IDLE instead.
  - Otherwise go to IDLE, with rgbfilter_o=000.
- en_i deasserted in SELECT, WAIT_FRAME or WAIT_RESULT: go to IDLE next cycle. No scan_done_o; best_*_o and found_o keep the last completed scan.
- best_*_o only change in the cycle scan_done_o is asserted.
- If no colour is detected: found_o=0, best_color_o=000, best_centroid_o=0, best_prox_o=0.
- The timeout counter saturates and does not wrap; its width must hold c_timeout_cycles.

Test Plan:
1. Reset, en_i=1, color_en_i=111; frames every 1000 cycles. Results: red c=0x08 p=2, green c=0x10 p=5, blue c=0x01 p=5 -> rgbfilter_o sequence 100, 010, 001. One scan_done_o with best_color_o=010, best_centroid_o=0x10, best_prox_o=5 (tie with blue keeps green). found_o=1.
2. color_en_i=101, all results centroid=0 -> only 100 then 001 driven. scan_done_o with found_o=0 and best_color_o=000, best_centroid_o=0, best_prox_o=0.
3. color_en_i=001, c_timeout_cycles=100, no new_centroid_i -> newframe_o once, timeout_o pulse 100 cycles after it. scan_done_o follows, found_o=0. Rescan starts because en_i=1.
4. Extra capture_newframe_i pulses during WAIT_RESULT and SELECT -> exactly one newframe_o per colour. newframe_o appears 1 cycle after an accepted capture.
5. After a completed scan (best_prox_o=4), drop en_i during the second colour's WAIT_RESULT -> IDLE next cycle, rgbfilter_o=000, busy_o=0, no scan_done_o, best_prox_o stays 4.
6. Assert rst low mid-WAIT_RESULT, asynchronously between clock edges -> all outputs 0 immediately. After release with en_i=1, the scan restarts at red.

Source files
------------

// File: rtl/color_scan_sched.sv
// Time-shares the colour-filter/centroid datapath across red, green and blue,
// admits one frame per enabled colour and publishes the best detected target.
module color_scan_sched #(
    parameter int unsigned c_nb_centroid    = 8,
    parameter int unsigned c_nb_prox        = 3,
    parameter int unsigned c_nb_timeout     = 20,
    parameter int unsigned c_timeout_cycles = 500000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [2:0]               color_en_i,
    input  logic                     capture_newframe_i,
    input  logic                     new_centroid_i,
    input  logic [c_nb_centroid-1:0] centroid_i,
    input  logic [c_nb_prox-1:0]     proximity_i,
    output logic [2:0]               rgbfilter_o,
    output logic                     newframe_o,
    output logic                     busy_o,
    output logic                     scan_done_o,
    output logic                     found_o,
    output logic [2:0]               best_color_o,
    output logic [c_nb_centroid-1:0] best_centroid_o,
    output logic [c_nb_prox-1:0]     best_prox_o,
    output logic                     timeout_o
);

    localparam logic [c_nb_timeout-1:0] c_cnt_last = c_nb_timeout'(c_timeout_cycles - 1);
    localparam logic [c_nb_timeout-1:0] c_cnt_max  = '1;

    localparam logic [2:0] c_red   = 3'b100;
    localparam logic [2:0] c_green = 3'b010;
    localparam logic [2:0] c_blue  = 3'b001;
    localparam logic [2:0] c_none  = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT_FRAME,
        S_WAIT_RESULT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               mask_q, mask_d;
    logic [c_nb_timeout-1:0]  cnt_q, cnt_d;

    // working best of the scan in progress
    logic                     w_found_q, w_found_d;
    logic [2:0]               w_color_q, w_color_d;
    logic [c_nb_centroid-1:0] w_cent_q, w_cent_d;
    logic [c_nb_prox-1:0]     w_prox_q, w_prox_d;

    // registered outputs
    logic [2:0]               rgbfilter_q, rgbfilter_d;
    logic                     newframe_q, newframe_d;
    logic                     busy_q, busy_d;
    logic                     scan_done_q, scan_done_d;
    logic                     found_q, found_d;
    logic [2:0]               best_color_q, best_color_d;
    logic [c_nb_centroid-1:0] best_cent_q, best_cent_d;
    logic [c_nb_prox-1:0]     best_prox_q, best_prox_d;
    logic                     timeout_q, timeout_d;

    // state, working and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mask_q       <= 3'b000;
            cnt_q        <= '0;
            w_found_q    <= 1'b0;
            w_color_q    <= 3'b000;
            w_cent_q     <= '0;
            w_prox_q     <= '0;
            rgbfilter_q  <= 3'b000;
            newframe_q   <= 1'b0;
            busy_q       <= 1'b0;
            scan_done_q  <= 1'b0;
            found_q      <= 1'b0;
            best_color_q <= 3'b000;
            best_cent_q  <= '0;
            best_prox_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            w_found_q    <= w_found_d;
            w_color_q    <= w_color_d;
            w_cent_q     <= w_cent_d;
            w_prox_q     <= w_prox_d;
            rgbfilter_q  <= rgbfilter_d;
            newframe_q   <= newframe_d;
            busy_q       <= busy_d;
            scan_done_q  <= scan_done_d;
            found_q      <= found_d;
            best_color_q <= best_color_d;
            best_cent_q  <= best_cent_d;
            best_prox_q  <= best_prox_d;
            timeout_q    <= timeout_d;
        end
    end

    // next-state, working-best update and output decode
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        w_found_d    = w_found_q;
        w_color_d    = w_color_q;
        w_cent_d     = w_cent_q;
        w_prox_d     = w_prox_q;
        rgbfilter_d  = rgbfilter_q;
        newframe_d   = 1'b0;
        scan_done_d  = 1'b0;
        timeout_d    = 1'b0;
        found_d      = found_q;
        best_color_d = best_color_q;
        best_cent_d  = best_cent_q;
        best_prox_d  = best_prox_q;

        case (state_q)
            S_IDLE: begin
                rgbfilter_d = c_none;
                if (en_i && (color_en_i != 3'b000)) begin
                    mask_d    = color_en_i;
                    w_found_d = 1'b0;
                    w_color_d = c_none;
                    w_cent_d  = '0;
                    w_prox_d  = '0;
                    state_d   = S_SELECT;
                end
            end

            S_SELECT: begin
                if (!en_i) begin
                    rgbfilter_d = c_none;
                    state_d     = S_IDLE;
                end else begin
                    // fixed priority red, green, blue; consumed colour leaves the mask
                    if (mask_q[2]) begin
                        rgbfilter_d = c_red;
                        mask_d      = mask_q & 3'b011;
                    end else if (mask_q[1]) begin
                        rgbfilter_d = c_green;
                        mask_d      = mask_q & 3'b001;
                    end else begin
                        rgbfilter_d = c_blue;
                        mask_d      = 3'b000;
                    end
                    state_d = S_WAIT_FRAME;
                end
            end

            S_WAIT_FRAME: begin
                if (!en_i) begin
                    rgbfilter_d = c_none;
                    state_d     = S_IDLE;
                end else if (capture_newframe_i) begin
                    newframe_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_WAIT_RESULT;
                end
            end

            S_WAIT_RESULT: begin
                if (!en_i) begin
                    rgbfilter_d = c_none;
                    state_d     = S_IDLE;
                end else if (new_centroid_i) begin
                    // strictly closer wins, so ties keep the earlier colour
                    if ((centroid_i != '0) && (!w_found_q || (proximity_i > w_prox_q))) begin
                        w_found_d = 1'b1;
                        w_color_d = rgbfilter_q;
                        w_cent_d  = centroid_i;
                        w_prox_d  = proximity_i;
                    end
                    state_d = (mask_q != 3'b000) ? S_SELECT : S_DONE;
                end else if (cnt_q >= c_cnt_last) begin
                    timeout_d = 1'b1;
                    state_d   = (mask_q != 3'b000) ? S_SELECT : S_DONE;
                end else if (cnt_q != c_cnt_max) begin
                    cnt_d = cnt_q + c_nb_timeout'(1);
                end
            end

            S_DONE: begin
                scan_done_d  = 1'b1;
                found_d      = w_found_q;
                best_color_d = w_color_q;
                best_cent_d  = w_cent_q;
                best_prox_d  = w_prox_q;
                if (en_i && (color_en_i != 3'b000)) begin
                    mask_d    = color_en_i;
                    w_found_d = 1'b0;
                    w_color_d = c_none;
                    w_cent_d  = '0;
                    w_prox_d  = '0;
                    state_d   = S_SELECT;
                end else begin
                    rgbfilter_d = c_none;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                rgbfilter_d = c_none;
                state_d     = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign rgbfilter_o     = rgbfilter_q;
    assign newframe_o      = newframe_q;
    assign busy_o          = busy_q;
    assign scan_done_o     = scan_done_q;
    assign found_o         = found_q;
    assign best_color_o    = best_color_q;
    assign best_centroid_o = best_cent_q;
    assign best_prox_o     = best_prox_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_color_scan_sched.sv
// Bench for color_scan_sched: directed scenarios plus randomized scans
// checked against a colour-by-colour reference model.
module tb_color_scan_sched;

    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic [2:0] color_en_i;
    logic       capture_newframe_i;
    logic       new_centroid_i;
    logic [7:0] centroid_i;
    logic [2:0] proximity_i;
    logic [2:0] rgbfilter_o;
    logic       newframe_o;
    logic       busy_o;
    logic       scan_done_o;
    logic       found_o;
    logic [2:0] best_color_o;
    logic [7:0] best_centroid_o;
    logic [2:0] best_prox_o;
    logic       timeout_o;

    color_scan_sched #(
        .c_nb_centroid   (8),
        .c_nb_prox       (3),
        .c_nb_timeout    (20),
        .c_timeout_cycles(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .en_i              (en_i),
        .color_en_i        (color_en_i),
        .capture_newframe_i(capture_newframe_i),
        .new_centroid_i    (new_centroid_i),
        .centroid_i        (centroid_i),
        .proximity_i       (proximity_i),
        .rgbfilter_o       (rgbfilter_o),
        .newframe_o        (newframe_o),
        .busy_o            (busy_o),
        .scan_done_o       (scan_done_o),
        .found_o           (found_o),
        .best_color_o      (best_color_o),
        .best_centroid_o   (best_centroid_o),
        .best_prox_o       (best_prox_o),
        .timeout_o         (timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // per-colour camera/centroid behaviour, index 2 red, 1 green, 0 blue
    bit         resp_valid [3];
    logic [7:0] resp_cent  [3];
    logic [2:0] resp_prox  [3];
    int         resp_delay [3];

    // observations of one scan
    logic [2:0] obs_seq [4];
    int         obs_nf, obs_to, obs_nf_cyc, obs_to_cyc, obs_lat_bad;
    bit         obs_done, obs_busy_done, obs_early;
    logic       obs_found;
    logic [2:0] obs_color;
    logic [7:0] obs_cent;
    logic [2:0] obs_prox;

    // reference model results
    logic [2:0] exp_seq [4];
    int         exp_n, exp_to;
    logic       exp_found;
    logic [2:0] exp_color;
    logic [7:0] exp_cent;
    logic [2:0] exp_prox;

    // Walk the enabled colours in red-green-blue order and keep the strictly closest detection.
    task automatic model_scan(input logic [2:0] mask);
        exp_n = 0; exp_to = 0; exp_found = 1'b0;
        exp_color = 3'b000; exp_cent = 8'h00; exp_prox = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            if (mask[k]) begin
                exp_seq[exp_n] = 3'(1 << k);
                exp_n++;
                if (!resp_valid[k]) exp_to++;
                else if (resp_cent[k] != 8'h00 && (!exp_found || resp_prox[k] > exp_prox)) begin
                    exp_found = 1'b1;
                    exp_color = 3'(1 << k);
                    exp_cent  = resp_cent[k];
                    exp_prox  = resp_prox[k];
                end
            end
        end
    endtask

    // Drive one scan: periodic camera captures, responses from resp_*, record what the DUT does.
    task automatic run_scan(input logic [2:0] mask, input int period, input int budget);
        int         pcnt, pdly, last_cap, idx;
        bit         pend;
        logic       s_found;
        logic [2:0] s_col, s_prox;
        logic [7:0] s_cent;
        obs_nf = 0; obs_to = 0; obs_nf_cyc = 0; obs_to_cyc = 0; obs_lat_bad = 0;
        obs_done = 0; obs_busy_done = 0; obs_early = 0;
        pcnt = 0; pdly = 0; pend = 0; last_cap = -10; idx = 0;
        @(negedge clk);
        s_found = found_o; s_col = best_color_o; s_cent = best_centroid_o; s_prox = best_prox_o;
        color_en_i = mask;
        en_i = 1'b1;
        for (int n = 0; n < budget && !obs_done; n++) begin
            @(negedge clk);
            capture_newframe_i = 1'b0;
            new_centroid_i = 1'b0;
            centroid_i = 8'($urandom);
            proximity_i = 3'($urandom);
            if (newframe_o) begin
                if (obs_nf < 4) obs_seq[obs_nf] = rgbfilter_o;
                obs_nf++;
                obs_nf_cyc = cyc;
                if (cyc != last_cap + 1) obs_lat_bad++;
                idx = rgbfilter_o[2] ? 2 : (rgbfilter_o[1] ? 1 : 0);
                if (resp_valid[idx]) begin pend = 1; pdly = resp_delay[idx]; end
            end
            if (timeout_o) begin obs_to++; obs_to_cyc = cyc; end
            if (scan_done_o) begin
                obs_done = 1;
                obs_busy_done = busy_o;
                obs_found = found_o; obs_color = best_color_o;
                obs_cent = best_centroid_o; obs_prox = best_prox_o;
                en_i = 1'b0;
            end else if (found_o !== s_found || best_color_o !== s_col ||
                         best_centroid_o !== s_cent || best_prox_o !== s_prox) begin
                obs_early = 1;
            end
            if (pend) begin
                if (pdly == 0) begin
                    new_centroid_i = 1'b1;
                    centroid_i = resp_cent[idx];
                    proximity_i = resp_prox[idx];
                    pend = 0;
                end else pdly--;
            end
            if (!obs_done) begin
                if (pcnt >= period - 1) begin capture_newframe_i = 1'b1; last_cap = cyc; pcnt = 0; end
                else pcnt++;
            end
        end
        capture_newframe_i = 1'b0;
        new_centroid_i = 1'b0;
        en_i = 1'b0;
        if (!obs_done) begin
            checks++; errors++;
            $display("FAIL scan_wait no scan_done_o within %0d cycles (mask %b)", budget, mask);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; en_i = 1'b0; color_en_i = 3'b000;
        capture_newframe_i = 1'b0; new_centroid_i = 1'b0;
        centroid_i = 8'h00; proximity_i = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rgbfilter_o, newframe_o, busy_o, scan_done_o, found_o, best_color_o,
             best_centroid_o, best_prox_o, timeout_o} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got rgb=%b nf=%b busy=%b done=%b found=%b col=%b c=%h p=%0d to=%b want all 0",
                     rgbfilter_o, newframe_o, busy_o, scan_done_o, found_o, best_color_o,
                     best_centroid_o, best_prox_o, timeout_o);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy_o); end
    endtask

    task automatic test_priority_scan();
        resp_valid[2] = 1; resp_cent[2] = 8'h08; resp_prox[2] = 3'd2; resp_delay[2] = 10;
        resp_valid[1] = 1; resp_cent[1] = 8'h10; resp_prox[1] = 3'd5; resp_delay[1] = 20;
        resp_valid[0] = 1; resp_cent[0] = 8'h01; resp_prox[0] = 3'd5; resp_delay[0] = 5;
        run_scan(3'b111, 1000, 5000);
        checks++; if (obs_nf !== 3) begin errors++; $display("FAIL prio_nf got %0d want 3", obs_nf); end
        checks++; if (obs_seq[0] !== 3'b100) begin errors++; $display("FAIL prio_seq0 got %b want 100", obs_seq[0]); end
        checks++; if (obs_seq[1] !== 3'b010) begin errors++; $display("FAIL prio_seq1 got %b want 010", obs_seq[1]); end
        checks++; if (obs_seq[2] !== 3'b001) begin errors++; $display("FAIL prio_seq2 got %b want 001", obs_seq[2]); end
        checks++; if (obs_found !== 1'b1) begin errors++; $display("FAIL prio_found got %b want 1", obs_found); end
        checks++; if (obs_color !== 3'b010) begin errors++; $display("FAIL prio_color got %b want 010", obs_color); end
        checks++; if (obs_cent !== 8'h10) begin errors++; $display("FAIL prio_cent got %h want 10", obs_cent); end
        checks++; if (obs_prox !== 3'd5) begin errors++; $display("FAIL prio_prox got %0d want 5", obs_prox); end
        checks++; if (obs_to !== 0) begin errors++; $display("FAIL prio_timeouts got %0d want 0", obs_to); end
        checks++; if (obs_early !== 0) begin errors++; $display("FAIL prio_best_early got %0d want 0", obs_early); end
    endtask

    task automatic test_no_detect();
        for (int k = 0; k < 3; k++) begin
            resp_valid[k] = 1; resp_cent[k] = 8'h00; resp_prox[k] = 3'($urandom_range(0, 7)); resp_delay[k] = 7;
        end
        run_scan(3'b101, 9, 2000);
        checks++; if (obs_nf !== 2) begin errors++; $display("FAIL nodet_nf got %0d want 2", obs_nf); end
        checks++; if (obs_seq[0] !== 3'b100) begin errors++; $display("FAIL nodet_seq0 got %b want 100", obs_seq[0]); end
        checks++; if (obs_seq[1] !== 3'b001) begin errors++; $display("FAIL nodet_seq1 got %b want 001", obs_seq[1]); end
        checks++;
        if ({obs_found, obs_color, obs_cent, obs_prox} !== 15'h0) begin
            errors++;
            $display("FAIL nodet_best got found=%b col=%b c=%h p=%0d want all 0", obs_found, obs_color, obs_cent, obs_prox);
        end
    endtask

    task automatic test_timeout();
        resp_valid[0] = 0;
        run_scan(3'b001, 7, 1000);
        checks++; if (obs_nf !== 1) begin errors++; $display("FAIL to_nf got %0d want 1", obs_nf); end
        checks++; if (obs_to !== 1) begin errors++; $display("FAIL to_pulses got %0d want 1", obs_to); end
        checks++;
        if (obs_to_cyc - obs_nf_cyc !== int'(TO)) begin
            errors++; $display("FAIL to_latency got %0d want %0d", obs_to_cyc - obs_nf_cyc, TO);
        end
        checks++; if (obs_found !== 1'b0) begin errors++; $display("FAIL to_found got %b want 0", obs_found); end
        checks++; if (obs_busy_done !== 1'b1) begin errors++; $display("FAIL to_rescan busy got %b want 1", obs_busy_done); end
    endtask

    task automatic test_extra_captures();
        resp_valid[2] = 1; resp_cent[2] = 8'h40; resp_prox[2] = 3'd3; resp_delay[2] = 15;
        resp_valid[1] = 1; resp_cent[1] = 8'h02; resp_prox[1] = 3'd6; resp_delay[1] = 30;
        resp_valid[0] = 1; resp_cent[0] = 8'h80; resp_prox[0] = 3'd6; resp_delay[0] = 8;
        run_scan(3'b111, 1, 1000);
        checks++; if (obs_nf !== 3) begin errors++; $display("FAIL extra_nf got %0d want 3", obs_nf); end
        checks++; if (obs_lat_bad !== 0) begin errors++; $display("FAIL extra_latency got %0d late newframes want 0", obs_lat_bad); end
        checks++; if (obs_color !== 3'b010) begin errors++; $display("FAIL extra_color got %b want 010", obs_color); end
        checks++; if (obs_cent !== 8'h02) begin errors++; $display("FAIL extra_cent got %h want 02", obs_cent); end
    endtask

    task automatic test_abort();
        int  nf, dly, n;
        bit  seen_done;
        resp_valid[2] = 1; resp_cent[2] = 8'h04; resp_prox[2] = 3'd4; resp_delay[2] = 3;
        resp_valid[1] = 1; resp_cent[1] = 8'h00; resp_prox[1] = 3'd7; resp_delay[1] = 3;
        resp_valid[0] = 1; resp_cent[0] = 8'h20; resp_prox[0] = 3'd3; resp_delay[0] = 3;
        run_scan(3'b111, 4, 1000);
        checks++; if (obs_prox !== 3'd4) begin errors++; $display("FAIL abort_first_prox got %0d want 4", obs_prox); end
        nf = 0; dly = -1; n = 0; seen_done = 0;
        color_en_i = 3'b111; en_i = 1'b1;
        while (nf < 2 && n < 2000) begin
            @(negedge clk);
            n++;
            capture_newframe_i = 1'b0; new_centroid_i = 1'b0;
            if (newframe_o) begin nf++; if (nf == 1) dly = 2; end
            if (scan_done_o) seen_done = 1;
            if (dly == 0) begin new_centroid_i = 1'b1; centroid_i = 8'h00; proximity_i = 3'd7; dly = -1; end
            else if (dly > 0) dly--;
            if (n % 4 == 0) capture_newframe_i = 1'b1;
        end
        capture_newframe_i = 1'b0; new_centroid_i = 1'b0;
        checks++; if (nf !== 2) begin errors++; $display("FAIL abort_reach got %0d newframes want 2", nf); end
        repeat (5) @(negedge clk);
        en_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_o); end
        checks++; if (rgbfilter_o !== 3'b000) begin errors++; $display("FAIL abort_filter got %b want 000", rgbfilter_o); end
        for (int i = 0; i < 10; i++) begin
            if (scan_done_o) seen_done = 1;
            @(negedge clk);
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", seen_done); end
        checks++; if (best_prox_o !== 3'd4) begin errors++; $display("FAIL abort_keep_prox got %0d want 4", best_prox_o); end
        checks++; if (found_o !== 1'b1) begin errors++; $display("FAIL abort_keep_found got %b want 1", found_o); end
    endtask

    task automatic test_async_reset();
        int nf, n;
        nf = 0; n = 0;
        color_en_i = 3'b111; en_i = 1'b1;
        while (nf < 1 && n < 500) begin
            @(negedge clk);
            n++;
            capture_newframe_i = 1'b0;
            if (newframe_o) nf++;
            if (n % 3 == 0) capture_newframe_i = 1'b1;
        end
        capture_newframe_i = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL areset_pre busy got %b want 1", busy_o); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({rgbfilter_o, newframe_o, busy_o, scan_done_o, found_o, best_color_o,
             best_centroid_o, best_prox_o, timeout_o} !== 24'h0) begin
            errors++;
            $display("FAIL areset_outputs got rgb=%b busy=%b found=%b col=%b c=%h p=%0d want all 0",
                     rgbfilter_o, busy_o, found_o, best_color_o, best_centroid_o, best_prox_o);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            resp_valid[k] = 1; resp_cent[k] = 8'(1 << k); resp_prox[k] = 3'(k + 1); resp_delay[k] = 4;
        end
        model_scan(3'b111);
        run_scan(3'b111, 5, 2000);
        checks++; if (obs_seq[0] !== 3'b100) begin errors++; $display("FAIL areset_restart got %b want 100", obs_seq[0]); end
        checks++; if (obs_color !== exp_color) begin errors++; $display("FAIL areset_color got %b want %b", obs_color, exp_color); end
    endtask

    task automatic test_random();
        logic [2:0] mask;
        int         period;
        for (int it = 0; it < 25; it++) begin
            mask = 3'($urandom_range(1, 7));
            period = $urandom_range(1, 40);
            for (int k = 0; k < 3; k++) begin
                resp_valid[k] = ($urandom_range(0, 9) != 0);
                resp_cent[k]  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                resp_prox[k]  = 3'($urandom_range(0, 7));
                resp_delay[k] = ($urandom_range(0, 5) == 0) ? int'(TO) - 1 : $urandom_range(0, 98);
            end
            model_scan(mask);
            run_scan(mask, period, 1500);
            checks++;
            if (obs_nf !== exp_n) begin errors++; $display("FAIL rnd%0d_nf got %0d want %0d", it, obs_nf, exp_n); end
            for (int j = 0; j < exp_n && j < obs_nf; j++) begin
                checks++;
                if (obs_seq[j] !== exp_seq[j]) begin errors++; $display("FAIL rnd%0d_seq%0d got %b want %b", it, j, obs_seq[j], exp_seq[j]); end
            end
            checks++;
            if (obs_to !== exp_to) begin errors++; $display("FAIL rnd%0d_timeouts got %0d want %0d", it, obs_to, exp_to); end
            checks++;
            if ({obs_found, obs_color, obs_cent, obs_prox} !== {exp_found, exp_color, exp_cent, exp_prox}) begin
                errors++;
                $display("FAIL rnd%0d_best got f=%b col=%b c=%h p=%0d want f=%b col=%b c=%h p=%0d", it,
                         obs_found, obs_color, obs_cent, obs_prox, exp_found, exp_color, exp_cent, exp_prox);
            end
            checks++;
            if (obs_early !== 0 || obs_lat_bad !== 0) begin
                errors++; $display("FAIL rnd%0d_timing got early=%0d late=%0d want 0 0", it, obs_early, obs_lat_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority_scan();
        test_no_detect();
        test_timeout();
        test_extra_captures();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
